core_btb_update: RTL and testbench

Branch-resolution side of the branch target buffer. It takes resolved branch/jump outcomes from the execute stage and compares them with the prediction carried down the pipe. It issues a registered redirect on mispredict and queues BTB write requests (tag allocate and/or target correct) in a small FIFO. The FIFO drains into the BTB write port whenever fetch grants that port.

---
 rtl/core_btb_update.sv | 141 ++++++++++++++
 tb/tb_core_btb_update.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_btb_update.sv
// core_btb_update: branch-resolution side of the BTB.
// Compares resolved control-transfer outcomes against the prediction carried
// down the pipe, issues a registered redirect on mispredict and queues BTB
// write requests (tag allocate / target correct) in a small FIFO that drains
// into the BTB write port whenever fetch grants it.
// Optional feature macro: BTB_UPD_STATS_EN (saturating resolve/mispredict
// counters). Without it the stat outputs are tied to zero.
module core_btb_update #(
    parameter int UPD_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [1:0]  ex_type,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_hit,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        btb_port_ready,
    output logic        update_btb_tag,
    output logic        update_btb_target,
    output logic [31:0] btb_pc_out,
    output logic [31:0] btb_target_in,
    output logic [1:0]  btb_type_in,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        queue_empty,
    output logic        queue_full,
    output logic [15:0] stat_resolved,
    output logic [15:0] stat_mispred
);

    // FIFO storage, one array per entry field
    logic [31:0] pc_mem   [UPD_DEPTH];
    logic [29:0] tgt_mem  [UPD_DEPTH];
    logic [1:0]  type_mem [UPD_DEPTH];
    logic        tag_mem  [UPD_DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    logic acc;
    logic tgt_diff;
    logic mis;
    logic push;
    logic pop;

    // Low target bits are always forced to zero, so they are never looked at
    logic unused_low_bits;
    assign unused_low_bits = ^{ex_target[1:0], ex_pred_target[1:0]};

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];

    assign queue_empty = (wr_ptr == rd_ptr);
    assign queue_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign ex_ready    = !queue_full;

    assign acc      = ex_valid && ex_ready;
    assign tgt_diff = (ex_target[31:2] != ex_pred_target[31:2]);
    assign mis      = (ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && tgt_diff);

    // Only taken outcomes touch the BTB: allocate on a miss, correct the
    // target on a hit that pointed elsewhere. The fetch-side entry type is
    // not carried down the pipe, so target mismatch is the correction cause.
    assign push = acc && ex_taken && (!ex_pred_hit || tgt_diff);
    assign pop  = !queue_empty && btb_port_ready;

    // Head entry drives the write port directly; gated to zero when empty
    assign btb_pc_out        = queue_empty ? 32'd0 : pc_mem[rd_idx];
    assign btb_target_in     = queue_empty ? 32'd0 : {tgt_mem[rd_idx], 2'b00};
    assign btb_type_in       = queue_empty ? 2'b00 : type_mem[rd_idx];
    assign update_btb_target = pop;
    assign update_btb_tag    = pop && tag_mem[rd_idx];

    // Entry write; storage needs no reset because the pointers gate it
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_idx]   <= ex_pc;
            tgt_mem[wr_idx]  <= ex_target[31:2];
            type_mem[wr_idx] <= ex_type;
            tag_mem[wr_idx]  <= !ex_pred_hit;
        end
    end

    // Pointer update; push and pop in the same cycle both advance
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Registered one-cycle redirect; the PC holds its last value between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= acc && mis;
            if (acc && mis)
                redirect_pc <= ex_taken ? {ex_target[31:2], 2'b00}
                                        : ex_pc + 32'd4;
        end
    end

`ifdef BTB_UPD_STATS_EN
    logic [15:0] res_cnt;
    logic [15:0] mis_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt <= 16'd0;
            mis_cnt <= 16'd0;
        end else begin
            if (acc && res_cnt != 16'hFFFF)        res_cnt <= res_cnt + 16'd1;
            if (acc && mis && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
        end
    end

    assign stat_resolved = res_cnt;
    assign stat_mispred  = mis_cnt;
`else
    assign stat_resolved = 16'h0000;
    assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_core_btb_update.sv
// Self-checking bench for core_btb_update. Expected redirects (with the cycle
// they must appear in) and expected BTB writes are queued when stimulus is
// accepted and compared by a negedge monitor; scenario tasks add inline checks.
module tb_core_btb_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [1:0]  ex_type;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_hit;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        btb_port_ready;
    logic        update_btb_tag;
    logic        update_btb_target;
    logic [31:0] btb_pc_out;
    logic [31:0] btb_target_in;
    logic [1:0]  btb_type_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        queue_empty;
    logic        queue_full;
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispred;

    core_btb_update #(.UPD_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_type(ex_type), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_hit(ex_pred_hit), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .btb_port_ready(btb_port_ready),
        .update_btb_tag(update_btb_tag), .update_btb_target(update_btb_target),
        .btb_pc_out(btb_pc_out), .btb_target_in(btb_target_in),
        .btb_type_in(btb_type_in), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .queue_empty(queue_empty),
        .queue_full(queue_full), .stat_resolved(stat_resolved),
        .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  ty;
        logic        tag;
    } upd_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } rdr_t;

    upd_t uq[$];
    rdr_t rq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   run = 0;
    int   max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: redirects by cycle stamp, BTB writes in FIFO order
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                n_cmp++; n_err++;
                $display("FAIL redirect_missing: expected pc %h in cycle %0d, got no pulse", rq[0].pc, rq[0].cyc);
                void'(rq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                n_cmp++;
                if (redirect_valid !== 1'b1 || redirect_pc !== rq[0].pc) begin
                    n_err++;
                    $display("FAIL redirect: got valid=%b pc=%h, want valid=1 pc=%h", redirect_valid, redirect_pc, rq[0].pc);
                end
                void'(rq.pop_front());
            end else if (redirect_valid !== 1'b0) begin
                n_cmp++; n_err++;
                $display("FAIL redirect_spurious: got valid=%b pc=%h, want valid=0", redirect_valid, redirect_pc);
            end
            if (update_btb_tag === 1'b1 && update_btb_target !== 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL strobe_pair: got tag=1 target=%b, want target=1", update_btb_target);
            end
            if (update_btb_target === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                n_cmp++;
                if (uq.size() == 0) begin
                    n_err++;
                    $display("FAIL write_spurious: got pc=%h tgt=%h, want no write", btb_pc_out, btb_target_in);
                end else begin
                    if (btb_pc_out !== uq[0].pc || btb_target_in !== uq[0].tgt ||
                        btb_type_in !== uq[0].ty || update_btb_tag !== uq[0].tag) begin
                        n_err++;
                        $display("FAIL write: got pc=%h tgt=%h ty=%b tag=%b, want pc=%h tgt=%h ty=%b tag=%b",
                                 btb_pc_out, btb_target_in, btb_type_in, update_btb_tag,
                                 uq[0].pc, uq[0].tgt, uq[0].ty, uq[0].tag);
                    end
                    void'(uq.pop_front());
                end
            end else begin
                run = 0;
            end
        end
    end

    // Present one resolution, wait (bounded) for acceptance, queue expectations
    task automatic issue(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                         input logic [31:0] tg, input logic hit, input logic pt,
                         input logic [31:0] ptg);
        logic ok;
        logic m;
        rdr_t r;
        upd_t u;
        ex_pc = pc; ex_type = ty; ex_taken = tk; ex_target = tg;
        ex_pred_hit = hit; ex_pred_taken = pt; ex_pred_target = ptg;
        ex_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (ex_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: pc=%h not accepted in 20 cycles, want accepted", pc);
            ex_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m = (tk != pt) || (tk && pt && tg[31:2] != ptg[31:2]);
        if (m) begin
            r.cyc = cyc;
            r.pc  = tk ? {tg[31:2], 2'b00} : pc + 32'd4;
            rq.push_back(r);
        end
        if (tk && (!hit || tg[31:2] != ptg[31:2])) begin
            u.pc = pc; u.tgt = {tg[31:2], 2'b00}; u.ty = ty; u.tag = !hit;
            uq.push_back(u);
        end
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; btb_port_ready = 1'b1;
        ex_pc = '0; ex_type = '0; ex_taken = 0; ex_target = '0;
        ex_pred_hit = 0; ex_pred_taken = 0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (queue_empty !== 1'b1 || queue_full !== 1'b0 || ex_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: got empty=%b full=%b ready=%b, want 1 0 1", queue_empty, queue_full, ex_ready);
        end
        n_cmp++;
        if (update_btb_tag !== 1'b0 || update_btb_target !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
            n_err++;
            $display("FAIL reset_strobes: got tag=%b tgt=%b rv=%b rpc=%h, want all 0", update_btb_tag, update_btb_target, redirect_valid, redirect_pc);
        end
        n_cmp++;
        if (btb_pc_out !== 32'd0 || btb_target_in !== 32'd0 || btb_type_in !== 2'b00 ||
            stat_resolved !== 16'd0 || stat_mispred !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got pc=%h tgt=%h ty=%b sr=%h sm=%h, want 0", btb_pc_out, btb_target_in, btb_type_in, stat_resolved, stat_mispred);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        btb_port_ready = 1'b1;
        issue(32'h100, 2'b01, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
            n_err++;
            $display("FAIL cold_redirect: got valid=%b pc=%h, want 1 00000400", redirect_valid, redirect_pc);
        end
        n_cmp++;
        if (update_btb_tag !== 1'b1 || update_btb_target !== 1'b1 || btb_pc_out !== 32'h100 ||
            btb_target_in !== 32'h400 || btb_type_in !== 2'b01) begin
            n_err++;
            $display("FAIL cold_write: got tag=%b tgt=%b pc=%h t=%h ty=%b, want 1 1 00000100 00000400 01",
                     update_btb_tag, update_btb_target, btb_pc_out, btb_target_in, btb_type_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrong_target();
        btb_port_ready = 1'b1;
        issue(32'h100, 2'b01, 1'b1, 32'h483, 1'b1, 1'b1, 32'h400);
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h480) begin
            n_err++;
            $display("FAIL wrongtgt_redirect: got valid=%b pc=%h, want 1 00000480", redirect_valid, redirect_pc);
        end
        n_cmp++;
        if (update_btb_target !== 1'b1 || update_btb_tag !== 1'b0 || btb_target_in !== 32'h480) begin
            n_err++;
            $display("FAIL wrongtgt_write: got tgt=%b tag=%b t=%h, want 1 0 00000480", update_btb_target, update_btb_tag, btb_target_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_not_taken();
        btb_port_ready = 1'b1;
        issue(32'h200, 2'b00, 1'b0, 32'h300, 1'b1, 1'b1, 32'h300);
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || queue_empty !== 1'b1 || update_btb_target !== 1'b0) begin
            n_err++;
            $display("FAIL not_taken: got rv=%b rpc=%h empty=%b wr=%b, want 1 00000204 1 0", redirect_valid, redirect_pc, queue_empty, update_btb_target);
        end
        // PC+4 wraps at the top of the address space
        issue(32'hFFFF_FFFC, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        n_cmp++;
        if (redirect_pc !== 32'h0) begin
            n_err++;
            $display("FAIL pc_wrap: got rpc=%h, want 00000000", redirect_pc);
        end
        // Correct taken prediction: no redirect, no write
        issue(32'h300, 2'b00, 1'b1, 32'h500, 1'b1, 1'b1, 32'h500);
        n_cmp++;
        if (redirect_valid !== 1'b0 || queue_empty !== 1'b1) begin
            n_err++;
            $display("FAIL correct_pred: got rv=%b empty=%b, want 0 1", redirect_valid, queue_empty);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        btb_port_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(32'h1000 + 32'(i * 16), 2'b10, 1'b1, 32'h2000 + 32'(i * 64), 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (queue_full !== 1'b1 || ex_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got full=%b ready=%b, want 1 0", queue_full, ex_ready);
        end
        ex_pc = 32'h1040; ex_type = 2'b11; ex_taken = 1'b1; ex_target = 32'h2100;
        ex_pred_hit = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        ex_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ex_ready !== 1'b0 || queue_full !== 1'b1 || update_btb_target !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: got ready=%b full=%b wr=%b, want 0 1 0", ex_ready, queue_full, update_btb_target);
        end
        @(posedge clk); #1;
        max_run = 0;
        btb_port_ready = 1'b1;
        issue(32'h1040, 2'b11, 1'b1, 32'h2100, 1'b0, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (max_run !== 5 || queue_empty !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: got run=%0d empty=%b, want 5 1", max_run, queue_empty);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        btb_port_ready = 1'b0;
        issue(32'h3000, 2'b01, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
        issue(32'h3010, 2'b10, 1'b1, 32'h5010, 1'b0, 1'b0, 32'h0);
        btb_port_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(32'h3020 + 32'(i * 16), 2'(i), 1'b1, 32'h5020 + 32'(i * 16), 1'b1, 1'b1, 32'h4000);
            n_cmp++;
            if (queue_empty !== 1'b0 || queue_full !== 1'b0 || update_btb_target !== 1'b1 || redirect_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_%0d: got empty=%b full=%b wr=%b rv=%b, want 0 0 1 1", i, queue_empty, queue_full, update_btb_target, redirect_valid);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (queue_empty !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain: got empty=%b, want 1", queue_empty);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        btb_port_ready = 1'b0;
        issue(32'h6000, 2'b01, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0);
        issue(32'h6010, 2'b01, 1'b1, 32'h7010, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        // New mispredict presented in the same cycle reset is asserted
        rst = 1'b1;
        btb_port_ready = 1'b1;
        ex_pc = 32'h6020; ex_type = 2'b00; ex_taken = 1'b0; ex_target = 32'h0;
        ex_pred_hit = 1'b1; ex_pred_taken = 1'b1; ex_pred_target = 32'h8000;
        ex_valid = 1'b1;
        uq.delete();
        rq.delete();
        @(posedge clk); #1;
        n_cmp++;
        if (queue_empty !== 1'b1 || ex_ready !== 1'b1 || redirect_valid !== 1'b0 ||
            update_btb_tag !== 1'b0 || update_btb_target !== 1'b0 || btb_pc_out !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: got empty=%b ready=%b rv=%b tag=%b wr=%b pc=%h, want 1 1 0 0 0 0",
                     queue_empty, ex_ready, redirect_valid, update_btb_tag, update_btb_target, btb_pc_out);
        end
        ex_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stats();
        btb_port_ready = 1'b1;
        issue(32'h200, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        issue(32'h100, 2'b01, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        issue(32'h300, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
`ifdef BTB_UPD_STATS_EN
        n_cmp++;
        if (stat_resolved !== 16'd3 || stat_mispred !== 16'd2) begin
            n_err++;
            $display("FAIL stats_count: got res=%0d mis=%0d, want 3 2", stat_resolved, stat_mispred);
        end
        @(posedge clk); #1;
        // Correctly predicted not-taken stream, long enough to saturate
        ex_pc = 32'h800; ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_hit = 1'b0;
        ex_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stat_resolved !== 16'hFFFF || stat_mispred !== 16'd2) begin
            n_err++;
            $display("FAIL stats_sat: got res=%h mis=%h, want ffff 0002", stat_resolved, stat_mispred);
        end
`else
        n_cmp++;
        if (stat_resolved !== 16'h0000 || stat_mispred !== 16'h0000) begin
            n_err++;
            $display("FAIL stats_off: got res=%h mis=%h, want 0000 0000", stat_resolved, stat_mispred);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_wrong_target();
        test_not_taken();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_stats();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left: got %0d writes %0d redirects outstanding, want 0 0", uq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
